// File: rtl/rf_alu_seq_pkg.sv
// Shared definitions for the register-file/ALU instruction sequencer:
// FSM state encoding, instruction type codes and flag bit positions.
package rf_alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic TYPE_ALU  = 1'b0;
    localparam logic TYPE_LOAD = 1'b1;

    // Flags bus is {ZF,CF,OF,SF,PF}, ZF in the MSB
    localparam int unsigned FLG_ZF = 4;
    localparam int unsigned FLG_CF = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_SF = 1;
    localparam int unsigned FLG_PF = 0;

    localparam logic [3:0] OP_MAX_DEF = 4'b0111;

endpackage

// File: rtl/rf_alu_seq.sv
// Multi-cycle sequencer: accepts one instruction over valid/ready and drives
// the register-file/ALU datapath control lines, latching ALU flags after EXEC.
module rf_alu_seq
    import rf_alu_seq_pkg::*;
#(
    parameter int unsigned ADDR   = 4,
    parameter int unsigned SIZE   = 32,
    parameter logic [3:0]  OP_MAX = OP_MAX_DEF
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Instr_Valid,
    output logic            Instr_Ready,
    input  logic            Instr_Type,
    input  logic            Instr_NoWB,
    input  logic [3:0]      Instr_OP,
    input  logic [ADDR-1:0] Instr_Rd,
    input  logic [ADDR-1:0] Instr_Rs,
    input  logic [ADDR-1:0] Instr_Rt,
    input  logic [SIZE-1:0] Instr_Imm,
    output logic            Write_Reg,
    output logic            Write_Select,
    output logic [ADDR-1:0] R_Addr_A,
    output logic [ADDR-1:0] R_Addr_B,
    output logic [ADDR-1:0] W_Addr,
    output logic [3:0]      OP,
    output logic [SIZE-1:0] Input_Data,
    input  logic            ZF,
    input  logic            CF,
    input  logic            OF,
    input  logic            SF,
    input  logic            PF,
    output logic [4:0]      Flags,
    output logic            Done,
    output logic            Err
);

    state_e          state_q, state_d;
    logic            wsel_q, wsel_d;
    logic [ADDR-1:0] ra_q, ra_d;
    logic [ADDR-1:0] rb_q, rb_d;
    logic [ADDR-1:0] wa_q, wa_d;
    logic [3:0]      op_q, op_d;
    logic [SIZE-1:0] data_q, data_d;
    logic [4:0]      flags_q, flags_d;
    logic            nowb_q, nowb_d;
    logic            ill_q, ill_d;

    always_comb begin
        state_d = state_q;
        wsel_d  = wsel_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        wa_d    = wa_q;
        op_d    = op_q;
        data_d  = data_q;
        flags_d = flags_q;
        nowb_d  = nowb_q;
        ill_d   = ill_q;

        unique case (state_q)
            IDLE: begin
                if (Instr_Valid) begin
                    wa_d = Instr_Rd;
                    if (Instr_Type == TYPE_LOAD) begin
                        data_d  = Instr_Imm;
                        wsel_d  = 1'b1;
                        nowb_d  = 1'b0;
                        ill_d   = 1'b0;
                        state_d = WB;
                    end else begin
                        ra_d    = Instr_Rs;
                        rb_d    = Instr_Rt;
                        op_d    = Instr_OP;
                        wsel_d  = 1'b0;
                        nowb_d  = Instr_NoWB;
                        ill_d   = (Instr_OP > OP_MAX);
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // Illegal opcodes leave the previous flags untouched and skip writeback
                if (!ill_q) begin
                    flags_d[FLG_ZF] = ZF;
                    flags_d[FLG_CF] = CF;
                    flags_d[FLG_OF] = OF;
                    flags_d[FLG_SF] = SF;
                    flags_d[FLG_PF] = PF;
                end
                state_d = (!ill_q && !nowb_q) ? WB : FIN;
            end
            WB:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= IDLE;
            wsel_q  <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            wa_q    <= '0;
            op_q    <= '0;
            data_q  <= '0;
            flags_q <= '0;
            nowb_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wsel_q  <= wsel_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wa_q    <= wa_d;
            op_q    <= op_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            nowb_q  <= nowb_d;
            ill_q   <= ill_d;
        end
    end

    // Strobes decode straight from the state register, so they are glitch-free
    // and drop to 0 in the cycle after a Clr edge.
    assign Instr_Ready  = (state_q == IDLE);
    assign Write_Reg    = (state_q == WB);
    assign Done         = (state_q == FIN);
    assign Err          = (state_q == FIN) && ill_q;
    assign Write_Select = wsel_q;
    assign R_Addr_A     = ra_q;
    assign R_Addr_B     = rb_q;
    assign W_Addr       = wa_q;
    assign OP           = op_q;
    assign Input_Data   = data_q;
    assign Flags        = flags_q;

endmodule

// File: tb/tb_rf_alu_seq.sv
// Scoreboard bench for rf_alu_seq: a behavioural register file + ALU stands in
// for the datapath; an architectural reference model predicts each instruction.
module tb_rf_alu_seq;
    import rf_alu_seq_pkg::*;

    localparam int unsigned ADDR = 4;
    localparam int unsigned SIZE = 32;

    logic            Clk = 1'b0;
    logic            Clr = 1'b1;
    logic            Instr_Valid = 1'b0;
    logic            Instr_Ready;
    logic            Instr_Type = 1'b0;
    logic            Instr_NoWB = 1'b0;
    logic [3:0]      Instr_OP = '0;
    logic [ADDR-1:0] Instr_Rd = '0;
    logic [ADDR-1:0] Instr_Rs = '0;
    logic [ADDR-1:0] Instr_Rt = '0;
    logic [SIZE-1:0] Instr_Imm = '0;
    logic            Write_Reg, Write_Select;
    logic [ADDR-1:0] R_Addr_A, R_Addr_B, W_Addr;
    logic [3:0]      OP;
    logic [SIZE-1:0] Input_Data;
    logic            ZF, CF, OF, SF, PF;
    logic [4:0]      Flags;
    logic            Done, Err;

    rf_alu_seq #(.ADDR(ADDR), .SIZE(SIZE), .OP_MAX(OP_MAX_DEF)) dut (
        .Clk(Clk), .Clr(Clr),
        .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
        .Instr_Type(Instr_Type), .Instr_NoWB(Instr_NoWB), .Instr_OP(Instr_OP),
        .Instr_Rd(Instr_Rd), .Instr_Rs(Instr_Rs), .Instr_Rt(Instr_Rt),
        .Instr_Imm(Instr_Imm),
        .Write_Reg(Write_Reg), .Write_Select(Write_Select),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
        .OP(OP), .Input_Data(Input_Data),
        .ZF(ZF), .CF(CF), .OF(OF), .SF(SF), .PF(PF),
        .Flags(Flags), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // ALU semantics for opcodes 0..7; returns {ZF,CF,OF,SF,PF,result}
    function automatic logic [36:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, o;
        w = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                        o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32];
                        o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: begin r = {a[30:0], 1'b0}; c = a[31]; end
            4'd7: r = a;
            default: r = '0;
        endcase
        return {(r == 32'd0), c, o, r[31], ~^r, r};
    endfunction

    // Behavioural datapath
    logic [31:0] dp_rf [16];
    logic [36:0] dp_out;
    always_comb dp_out = alu_f(OP, dp_rf[R_Addr_A], dp_rf[R_Addr_B]);
    assign {ZF, CF, OF, SF, PF} = dp_out[36:32];
    always @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < 16; i++) dp_rf[i] <= '0;
        end else if (Write_Reg) begin
            dp_rf[W_Addr] <= Write_Select ? Input_Data : dp_out[31:0];
        end
    end

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        err;
        logic [4:0]  flags;
        logic [3:0]  lat;
        logic        wr;
        logic [3:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_rf [16];
    logic [4:0]  ref_flags;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    bit          fin_req = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_rf[i] = '0;
        ref_flags = '0;
    endtask

    task automatic push_exp(input logic ty, input logic nowb, input logic [3:0] op,
                            input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [31:0] imm);
        exp_t        e;
        logic [36:0] o;
        e = '0;
        if (ty == TYPE_LOAD) begin
            e.wr = 1'b1; e.waddr = rd; e.wdata = imm; e.lat = 4'd2; e.flags = ref_flags;
            ref_rf[rd] = imm;
        end else if (op > 4'd7) begin
            e.err = 1'b1; e.lat = 4'd2; e.flags = ref_flags;
        end else begin
            o = alu_f(op, ref_rf[rs], ref_rf[rt]);
            ref_flags = o[36:32];
            e.flags = ref_flags;
            if (nowb) begin
                e.lat = 4'd2;
            end else begin
                e.lat = 4'd3; e.wr = 1'b1; e.waddr = rd; e.wdata = o[31:0];
                ref_rf[rd] = o[31:0];
            end
        end
        sb.push_back(e);
    endtask

    task automatic scramble();
        Instr_Type = 1'($urandom); Instr_NoWB = 1'($urandom); Instr_OP = 4'($urandom);
        Instr_Rd = 4'($urandom); Instr_Rs = 4'($urandom); Instr_Rt = 4'($urandom);
        Instr_Imm = $urandom;
    endtask

    // Called just after a rising edge; returns just after the edge that follows acceptance
    task automatic issue(input logic ty, input logic nowb, input logic [3:0] op,
                         input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [31:0] imm, input bit hold);
        bit got;
        Instr_Valid = 1'b1; Instr_Type = ty; Instr_NoWB = nowb; Instr_OP = op;
        Instr_Rd = rd; Instr_Rs = rs; Instr_Rt = rt; Instr_Imm = imm;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge Clk);
            if (Instr_Ready === 1'b1) got = 1'b1;
        end
        if (got) push_exp(ty, nowb, op, rd, rs, rt, imm);
        @(posedge Clk); #1;
        if (!hold || !got) begin
            Instr_Valid = 1'b0;
            scramble();
        end
    endtask

    task automatic reset_in_wb(input logic ty, input logic [3:0] op, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt, input logic [31:0] imm);
        bit seen;
        issue(ty, 1'b0, op, rd, rs, rt, imm, 1'b0);
        seen = 1'b0;
        for (int w = 0; w < 6 && !seen; w++) begin
            @(negedge Clk);
            if (Write_Reg === 1'b1) seen = 1'b1;
        end
        #1 Clr = 1'b1;
        ref_reset();
        @(posedge Clk);
        @(posedge Clk); #1 Clr = 1'b0;
    endtask

    // Monitor: samples on the falling edge and retires scoreboard entries on Done
    initial begin
        exp_t        e;
        int unsigned acc_cyc = 0, wr_cyc = 0, nwr = 0;
        logic [3:0]  wr_addr = '0;
        logic [31:0] wr_data = '0;
        bit          pending = 1'b0, ready_next = 1'b0, final_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (Clr) begin
                sb.delete();
                nwr = 0; pending = 1'b0; ready_next = 1'b0;
                chk("reset_outputs", 64'({Write_Reg, Write_Select, R_Addr_A, R_Addr_B, W_Addr,
                                          OP, Input_Data, Flags, Done, Err}), 64'd0);
                chk("reset_ready", 64'(Instr_Ready), 64'd1);
            end else begin
                if (ready_next) begin
                    chk("ready_after_fin", 64'(Instr_Ready), 64'd1);
                    ready_next = 1'b0;
                end
                if (Instr_Valid && Instr_Ready) begin
                    acc_cyc = cyc; pending = 1'b1; nwr = 0;
                end
                if (Write_Reg === 1'b1) begin
                    nwr++; wr_cyc = cyc; wr_addr = W_Addr;
                    wr_data = Write_Select ? Input_Data : dp_out[31:0];
                end
                if (Err === 1'b1 && Done !== 1'b1) begin
                    n_cmp++; n_fail++;
                    $display("FAIL err_without_done: got Err=1 Done=%b expected Done=1", Done);
                end
                if (Done === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("done_latency", 64'(cyc - acc_cyc), 64'(e.lat));
                        chk("err", 64'(Err), 64'(e.err));
                        chk("flags", 64'(Flags), 64'(e.flags));
                        chk("write_count", 64'(nwr), 64'(e.wr));
                        chk("ready_in_fin", 64'(Instr_Ready), 64'd0);
                        if (e.wr && nwr == 1) begin
                            chk("wb_latency", 64'(wr_cyc - acc_cyc), 64'(e.lat - 4'd1));
                            chk("w_addr", 64'(wr_addr), 64'(e.waddr));
                            chk("w_data", 64'(wr_data), 64'(e.wdata));
                        end
                    end
                    pending = 1'b0; nwr = 0; ready_next = 1'b1;
                end else if (pending && (cyc - acc_cyc) > 8) begin
                    n_cmp++; n_fail++;
                    $display("FAIL done_timeout: got no Done after %0d cycles expected at most 3", cyc - acc_cyc);
                    pending = 1'b0;
                end
                if (fin_req && !final_done) begin
                    chk("sb_empty", 64'(sb.size()), 64'd0);
                    final_done = 1'b1;
                end
            end
        end
    end

    // Driver: directed sequence, then randomized instructions
    initial begin
        logic        ty, nowb;
        logic [3:0]  op;
        logic [31:0] imm;
        ref_reset();
        repeat (2) @(posedge Clk);
        #1 Clr = 1'b0;

        issue(TYPE_LOAD, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 32'h0000_0005, 1'b0);
        issue(TYPE_LOAD, 1'b0, 4'd0, 4'd2, 4'd0, 4'd0, 32'h0000_0003, 1'b0);
        issue(TYPE_ALU,  1'b0, 4'd0, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0);
        issue(TYPE_ALU,  1'b1, 4'd1, 4'd3, 4'd1, 4'd1, 32'd0, 1'b0);
        issue(TYPE_ALU,  1'b0, 4'hF, 4'd4, 4'd1, 4'd2, 32'd0, 1'b0);
        // Valid held high across three back-to-back instructions
        issue(TYPE_ALU,  1'b0, 4'd0, 4'd5, 4'd3, 4'd3, 32'd0, 1'b1);
        issue(TYPE_LOAD, 1'b0, 4'd0, 4'd3, 4'd0, 4'd0, 32'h8000_0000, 1'b1);
        issue(TYPE_ALU,  1'b0, 4'd0, 4'd6, 4'd3, 4'd3, 32'd0, 1'b0);
        reset_in_wb(TYPE_ALU, 4'd0, 4'd7, 4'd1, 4'd2, 32'd0);

        for (int n = 0; n < 200; n++) begin
            ty   = ($urandom_range(0, 3) == 0) ? TYPE_LOAD : TYPE_ALU;
            nowb = ($urandom_range(0, 4) == 0);
            op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       imm = 32'd0;
                1:       imm = 32'hFFFF_FFFF;
                2:       imm = 32'h7FFF_FFFF;
                3:       imm = 32'h8000_0000;
                default: imm = $urandom;
            endcase
            if (n == 100) begin
                reset_in_wb(TYPE_LOAD, 4'd0, 4'($urandom), 4'd0, 4'd0, imm);
            end else begin
                issue(ty, nowb, op, 4'($urandom), 4'($urandom), 4'($urandom), imm,
                      ($urandom_range(0, 1) == 1));
                if (!Instr_Valid) repeat ($urandom_range(0, 2)) @(posedge Clk);
                #1;
            end
        end

        Instr_Valid = 1'b0;
        repeat (6) @(posedge Clk);
        fin_req = 1'b1;
        repeat (3) @(posedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_alu_seq.md
Name: rf_alu_seq

Overview:
Multi-cycle sequencer for the register-file + ALU datapath. It accepts one instruction at a time over a valid/ready handshake and drives the datapath control lines for that instruction.
- Instruction kinds: load an immediate, or execute a register-register ALU op.
- Drives Write_Reg, Write_Select, read/write addresses, OP and Input_Data, then latches the ALU flags.
- Sits between an instruction source (testbench, switch panel or future control unit) and the existing datapath, which is instantiated alongside it at top level.

Parameters:
ADDR, 4, register address width (16 registers)
SIZE, 32, data width
OP_MAX, 4'b0111, highest legal ALU opcode; opcodes above this are illegal

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  synchronous active-high reset
Instr_Valid  in  1  instruction present
Instr_Ready  out  1  sequencer can accept (combinational: state==IDLE)
Instr_Type  in  1  0=ALU op, 1=load immediate
Instr_NoWB  in  1  ALU op updates flags only, no register write
Instr_OP  in  4  ALU opcode
Instr_Rd  in  ADDR  destination register
Instr_Rs  in  ADDR  source A register
Instr_Rt  in  ADDR  source B register
Instr_Imm  in  SIZE  immediate for load
Write_Reg  out  1  to datapath write enable
Write_Select  out  1  to datapath: 1=Input_Data, 0=ALU result
R_Addr_A  out  ADDR  to datapath
R_Addr_B  out  ADDR  to datapath
W_Addr  out  ADDR  to datapath
OP  out  4  to datapath
Input_Data  out  SIZE  to datapath
ZF, CF, OF, SF, PF  in  1 each  datapath flags
Flags  out  5  latched {ZF,CF,OF,SF,PF}
Done  out  1  one-cycle completion pulse
Err  out  1  one-cycle illegal-op pulse, coincident with Done

Behaviour:
- Clock and reset are decided: single clock Clk; reset Clr is synchronous and active-high.
- Reset (Clr high at a rising edge):
  - State goes to IDLE.
  - All registered outputs go to 0: Write_Reg, Write_Select, R_Addr_A, R_Addr_B, W_Addr, OP, Input_Data, Flags, Done, Err.
  - Clr overrides any operation in progress. Write_Reg is 0 in the cycle after, so no write completes after the reset edge.
- Handshake:
  - Accept = Instr_Valid && Instr_Ready at a rising edge.
  - All instruction fields are captured into registers on accept; the inputs may change afterwards.
  - Instr_Valid without Instr_Ready is held by the source; the sequencer ignores it.
- FSM states: IDLE, EXEC, WB, FIN.
  - IDLE: Write_Reg=0. On accept of a load: Input_Data<=Imm, Write_Select<=1, W_Addr<=Rd, go to WB.
  - IDLE: on accept of an ALU op: R_Addr_A<=Rs, R_Addr_B<=Rt, W_Addr<=Rd, OP<=Instr_OP, Write_Select<=0, go to EXEC.
  - EXEC: one cycle for operand read and ALU settle. At the end of EXEC, Flags<={ZF,CF,OF,SF,PF}.
    - Legal op with NoWB=0: go to WB.
    - Otherwise (NoWB=1 or illegal op): go to FIN.
  - WB: Write_Reg=1 for exactly one cycle; the register write happens at the closing edge. Go to FIN.
  - FIN: Done=1 for one cycle (Err=1 if illegal). Go to IDLE.
- Illegal op (Instr_OP > OP_MAX): flags are NOT updated and no write occurs.
- Output hold: addresses, OP and Input_Data hold their values through FIN and IDLE until the next accept, so the datapath outputs stay observable.
- Latency, counted in cycles after the accept edge:
  - ALU op: EXEC=+1, WB=+2, Done=+3.
  - NoWB or illegal op: Done=+2.
  - Load: WB=+1, Done=+2.
- Throughput: next accept at the earliest in the cycle after FIN. Instr_Ready is 0 during FIN.
- Rd equal to Rs or Rt: legal. Operands are stable throughout EXEC/WB, and the new value is visible only after the WB edge.
- Load does not touch Flags.

Decomposition:
- Package rf_alu_seq_pkg holds:
  - the state encoding (IDLE, EXEC, WB, FIN);
  - TYPE_ALU / TYPE_LOAD constants;
  - flag bit indices FLG_ZF..FLG_PF;
  - the OP_MAX default.
- Single module with no sub-module; the FSM and the instruction register are small.
- Top-level wrapper rf_alu_sys instantiates rf_alu_seq and RF_ALU.

Test Plan:
1. Clr for 2 cycles, then load Imm=32'h0000_0005 into R1 -> Instr_Ready=0 for the following 2 cycles; Write_Reg=1 at +1 with W_Addr=1, Write_Select=1; Done at +2; R1 reads 5.
2. Load R2=3, then ALU add (legal OP) with Rd=3, Rs=1, Rt=2 -> Write_Reg only at +2, W_Addr=3; R3=8; Flags ZF=0, CF=0; Done at +3.
3. NoWB subtract with R1-R1 -> no Write_Reg pulse; Flags ZF=1; Done at +2; R3 unchanged.
4. Instr_OP=4'b1111 -> Err=1 with Done at +2; no write; Flags equal to the previous value.
5. Instr_Valid held high across 3 instructions -> accepts are spaced 4/3 cycles apart; Instr_Ready=0 in EXEC/WB/FIN; no instruction lost or duplicated.
6. Clr asserted during WB of a write -> next cycle in IDLE, all outputs 0, no Done pulse; the destination register is cleared by the datapath reset.
